// File: rtl/fmps_readout_sequencer_if.sv
// AXI-stream style packet channel from the FMPS readout sequencer to its consumer.
interface fmps_readout_sequencer_if;
    logic        M_TVALID;
    logic        M_TREADY;
    logic [31:0] M_TDATA;
    logic        M_TLAST;

    modport master (output M_TVALID, M_TDATA, M_TLAST, input M_TREADY);
    modport slave  (input M_TVALID, M_TDATA, M_TLAST, output M_TREADY);
endinterface

// File: rtl/fmps_readout_sequencer.sv
// Per-FA-cycle collection window and DPRAM-to-stream packet sequencer.
// Optional trailing XOR checksum word: define FMPS_SEQ_CHECKSUM_EN.
module fmps_readout_sequencer #(
    parameter int INDEX_WIDTH   = 5,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                           sysClk,
    input  logic                           sysReset_n,
    input  logic                           FAstrobe,
    input  logic [(1<<INDEX_WIDTH)-1:0]    enableMask,
    input  logic [TIMEOUT_WIDTH-1:0]       timeoutCycles,
    input  logic [(1<<INDEX_WIDTH)-1:0]    fmpsBitmap,
    output logic                           allFMPSpresent,
    output logic [INDEX_WIDTH-1:0]         readoutAddress,
    input  logic [31:0]                    readoutFMPS,
    output logic                           timeoutStrobe,
    output logic                           overrunStrobe,
    output logic                           busy,
    fmps_readout_sequencer_if.master       stream
);
    localparam int NSLOT = 1 << INDEX_WIDTH;
    localparam logic [31:0] MISSING = 32'h8000_0000;
`ifdef FMPS_SEQ_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, COLLECT, READ, SEND} state_t;

    function automatic logic [14:0] popcount(input logic [NSLOT-1:0] v);
        logic [14:0] n;
        n = '0;
        for (int i = 0; i < NSLOT; i++) n = n + 15'(v[i]);
        return n;
    endfunction

    state_t                   state;
    logic [NSLOT-1:0]         mask_q, bmp_q, mask_rem;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic                     timed_out, hdr_pend, rd_pend;
    logic [14:0]              present_cnt;
    logic [INDEX_WIDTH-1:0]   idx;
    logic [31:0]              chk;

    logic [NSLOT-1:0] hit, idx_bit;
    logic             window_done, last_slot;
    logic [31:0]      header;
    logic             load_en, load_last;
    logic [31:0]      load_word;

    assign hit            = fmpsBitmap & mask_q;
    assign window_done    = (hit == mask_q);
    assign idx_bit        = NSLOT'(1) << idx;
    assign last_slot      = ((mask_rem & ~idx_bit) == '0);
    assign header         = {16'hA5F0, timed_out, present_cnt};
    assign readoutAddress = idx;
    assign busy           = (state != IDLE);

    // Word selection for READ; a present slot spends one cycle waiting on the DPRAM.
    always_comb begin
        load_en   = 1'b0;
        load_word = header;
        load_last = 1'b0;
        if (state == READ) begin
            if (hdr_pend) begin
                load_en   = 1'b1;
                load_last = !CHK_EN && (mask_q == '0);
            end else if (rd_pend) begin
                load_en   = 1'b1;
                load_word = readoutFMPS;
                load_last = !CHK_EN && last_slot;
            end else if (mask_rem == '0) begin
                load_en   = CHK_EN;
                load_word = chk;
                load_last = 1'b1;
            end else if (mask_rem[idx] && !bmp_q[idx]) begin
                load_en   = 1'b1;
                load_word = MISSING;
                load_last = !CHK_EN && last_slot;
            end
        end
    end

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state           <= IDLE;
            mask_q          <= '0;
            bmp_q           <= '0;
            mask_rem        <= '0;
            timer           <= '0;
            timed_out       <= 1'b0;
            hdr_pend        <= 1'b0;
            rd_pend         <= 1'b0;
            present_cnt     <= '0;
            idx             <= '0;
            chk             <= '0;
            allFMPSpresent  <= 1'b0;
            timeoutStrobe   <= 1'b0;
            overrunStrobe   <= 1'b0;
            stream.M_TVALID <= 1'b0;
            stream.M_TDATA  <= '0;
            stream.M_TLAST  <= 1'b0;
        end else begin
            timeoutStrobe <= 1'b0;
            overrunStrobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (FAstrobe) begin
                        mask_q         <= enableMask;
                        timer          <= timeoutCycles;
                        allFMPSpresent <= 1'b0;
                        state          <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (FAstrobe) begin
                        mask_q <= enableMask;
                        timer  <= timeoutCycles;
                    end else if (window_done || timer == '0) begin
                        // Completion wins over a simultaneous timeout.
                        allFMPSpresent <= 1'b1;
                        timed_out      <= !window_done;
                        timeoutStrobe  <= !window_done;
                        present_cnt    <= popcount(hit);
                        bmp_q          <= fmpsBitmap;
                        mask_rem       <= mask_q;
                        idx            <= '0;
                        hdr_pend       <= 1'b1;
                        rd_pend        <= 1'b0;
                        chk            <= '0;
                        state          <= READ;
                    end else begin
                        timer <= timer - TIMEOUT_WIDTH'(1);
                    end
                end
                READ: begin
                    if (FAstrobe) overrunStrobe <= 1'b1;
                    if (hdr_pend) begin
                        hdr_pend <= 1'b0;
                    end else if (rd_pend) begin
                        rd_pend  <= 1'b0;
                        mask_rem <= mask_rem & ~idx_bit;
                        idx      <= idx + INDEX_WIDTH'(1);
                    end else if (mask_rem == '0) begin
                        if (!CHK_EN) state <= IDLE;
                    end else if (!mask_rem[idx]) begin
                        idx <= idx + INDEX_WIDTH'(1);
                    end else if (bmp_q[idx]) begin
                        rd_pend <= 1'b1;
                    end else begin
                        mask_rem <= mask_rem & ~idx_bit;
                        idx      <= idx + INDEX_WIDTH'(1);
                    end
                    if (load_en) begin
                        stream.M_TVALID <= 1'b1;
                        stream.M_TDATA  <= load_word;
                        stream.M_TLAST  <= load_last;
                        chk             <= chk ^ load_word;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    if (FAstrobe) overrunStrobe <= 1'b1;
                    if (stream.M_TREADY) begin
                        stream.M_TVALID <= 1'b0;
                        state           <= stream.M_TLAST ? IDLE : READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmps_readout_sequencer.sv
// Scoreboard bench for fmps_readout_sequencer: expected packets queued at stimulus time.
module tb_fmps_readout_sequencer;
    localparam int IW = 5;
    localparam int NS = 1 << IW;
    localparam int TW = 16;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    logic          sysClk = 1'b0;
    logic          sysReset_n = 1'b0;
    logic          FAstrobe = 1'b0;
    logic [NS-1:0] enableMask = '0;
    logic [NS-1:0] fmpsBitmap = '0;
    logic [TW-1:0] timeoutCycles = '0;
    logic          allFMPSpresent;
    logic [IW-1:0] readoutAddress;
    logic [31:0]   readoutFMPS = '0;
    logic          timeoutStrobe, overrunStrobe, busy;

    logic [31:0]   dpram [NS];
    beat_t         exp_q [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            strobe_cyc = 0;
    int            to_cyc = 0;
    int            to_count = 0;
    int            ov_count = 0;
    int            ready_mode = 0;

    fmps_readout_sequencer_if bus ();

    fmps_readout_sequencer #(.INDEX_WIDTH(IW), .TIMEOUT_WIDTH(TW)) dut (
        .sysClk         (sysClk),
        .sysReset_n     (sysReset_n),
        .FAstrobe       (FAstrobe),
        .enableMask     (enableMask),
        .timeoutCycles  (timeoutCycles),
        .fmpsBitmap     (fmpsBitmap),
        .allFMPSpresent (allFMPSpresent),
        .readoutAddress (readoutAddress),
        .readoutFMPS    (readoutFMPS),
        .timeoutStrobe  (timeoutStrobe),
        .overrunStrobe  (overrunStrobe),
        .busy           (busy),
        .stream         (bus.master)
    );

    always #5 sysClk = ~sysClk;

    always @(posedge sysClk) readoutFMPS <= dpram[readoutAddress];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference packet built straight from the packet format.
    task automatic push_packet(input logic [NS-1:0] m, input logic [NS-1:0] b, input logic to);
        logic [31:0] w, x;
        int cnt, last_i;
        cnt = 0;
        last_i = -1;
        for (int i = 0; i < NS; i++) begin
            if (m[i] && b[i]) cnt++;
            if (m[i]) last_i = i;
        end
        w = {16'hA5F0, to, 15'(cnt)};
        x = w;
`ifdef FMPS_SEQ_CHECKSUM_EN
        exp_q.push_back({1'b0, w});
`else
        exp_q.push_back({(last_i < 0), w});
`endif
        for (int i = 0; i < NS; i++) begin
            if (m[i]) begin
                w = b[i] ? dpram[i] : 32'h8000_0000;
                x = x ^ w;
`ifdef FMPS_SEQ_CHECKSUM_EN
                exp_q.push_back({1'b0, w});
`else
                exp_q.push_back({(i == last_i), w});
`endif
            end
        end
`ifdef FMPS_SEQ_CHECKSUM_EN
        exp_q.push_back({1'b1, x});
`endif
    endtask

    // TREADY driver: 0 = held low, 1 = held high, 2 = random 50%.
    initial begin
        bus.M_TREADY = 1'b0;
        forever begin
            @(posedge sysClk);
            #1;
            case (ready_mode)
                0:       bus.M_TREADY = 1'b0;
                1:       bus.M_TREADY = 1'b1;
                default: bus.M_TREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Every presented beat, stalled or not, must equal the head of the queue.
    initial begin
        forever begin
            @(negedge sysClk);
            cyc++;
            if (sysReset_n) begin
                if (timeoutStrobe) begin
                    to_count++;
                    to_cyc = cyc;
                end
                if (overrunStrobe) ov_count++;
                if (bus.M_TVALID) begin
                    if (exp_q.size() == 0) begin
                        chk_eq("unexpected_beat", 64'(bus.M_TDATA), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk_eq("tdata", 64'(bus.M_TDATA), 64'(exp_q[0].data));
                        chk_eq("tlast", 64'(bus.M_TLAST), 64'(exp_q[0].last));
                        if (bus.M_TREADY) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic fa_pulse();
        @(posedge sysClk);
        #1 FAstrobe = 1'b1;
        @(posedge sysClk);
        strobe_cyc = cyc;
        #1 FAstrobe = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < max) begin
            @(negedge sysClk);
            n++;
        end
        chk_eq({tag, "_finished"}, 64'(n < max), 64'd1);
        chk_eq({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_present(input string tag, input int max, output int n);
        n = 0;
        while (!allFMPSpresent && n < max) begin
            @(negedge sysClk);
            n++;
        end
        chk_eq({tag, "_present_seen"}, 64'(allFMPSpresent), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int n, ov0, to0;
        for (int i = 0; i < NS; i++) dpram[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0203);

        // Reset state
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        chk_eq("rst_tvalid", 64'(bus.M_TVALID), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_present", 64'(allFMPSpresent), 64'd0);
        chk_eq("rst_tlast", 64'(bus.M_TLAST), 64'd0);
        chk_eq("rst_addr", 64'(readoutAddress), 64'd0);
        @(posedge sysClk);
        #1 sysReset_n = 1'b1;
        ready_mode = 1;

        // 1: all enabled slots arrive, 10 cycles into the window
        to0 = to_count;
        enableMask = 32'h5; fmpsBitmap = '0; timeoutCycles = 16'd100;
        push_packet(32'h5, 32'h5, 1'b0);
        fa_pulse();
        @(negedge sysClk);
        chk_eq("t1_present_cleared", 64'(allFMPSpresent), 64'd0);
        chk_eq("t1_busy", 64'(busy), 64'd1);
        repeat (8) @(posedge sysClk);
        #1 fmpsBitmap = 32'h5;
        wait_present("t1", 10, n);
        chk_eq("t1_present_latency_ok", 64'(n <= 3), 64'd1);
        wait_done("t1", 200);
        chk_eq("t1_no_timeout", 64'(to_count - to0), 64'd0);
        chk_eq("t1_present_held", 64'(allFMPSpresent), 64'd1);

        // 2: timeout with a missing slot; later bitmap changes must be ignored
        to0 = to_count;
        enableMask = 32'h7; fmpsBitmap = 32'h2; timeoutCycles = 16'd20;
        push_packet(32'h7, 32'h2, 1'b1);
        fa_pulse();
        wait_present("t2", 40, n);
        fmpsBitmap = 32'h7;
        wait_done("t2", 200);
        chk_eq("t2_timeout_count", 64'(to_count - to0), 64'd1);
        chk_eq("t2_timeout_latency_ok", 64'((to_cyc - strobe_cyc) >= 20 && (to_cyc - strobe_cyc) <= 22), 64'd1);

        // 3: test 1 data under random back-pressure
        ready_mode = 2;
        enableMask = 32'h5; fmpsBitmap = 32'h5; timeoutCycles = 16'd100;
        push_packet(32'h5, 32'h5, 1'b0);
        fa_pulse();
        wait_done("t3", 400);

        // Window restart in COLLECT is not an overrun
        ready_mode = 1;
        ov0 = ov_count;
        enableMask = 32'h3; fmpsBitmap = '0; timeoutCycles = 16'd50;
        fa_pulse();
        repeat (3) @(posedge sysClk);
        enableMask = 32'h1;
        push_packet(32'h1, 32'h1, 1'b0);
        fa_pulse();
        #1 fmpsBitmap = 32'h1;
        wait_done("restart", 200);
        chk_eq("restart_no_overrun", 64'(ov_count - ov0), 64'd0);

        // 4: FAstrobe while the packet is streaming
        ready_mode = 2;
        ov0 = ov_count;
        enableMask = 32'hFF; fmpsBitmap = 32'hA5; timeoutCycles = 16'd10;
        push_packet(32'hFF, 32'hA5, 1'b1);
        fa_pulse();
        n = 0;
        while (!bus.M_TVALID && n < 100) begin
            @(negedge sysClk);
            n++;
        end
        chk_eq("t4_stream_started", 64'(bus.M_TVALID), 64'd1);
        fa_pulse();
        wait_done("t4", 600);
        chk_eq("t4_overrun_count", 64'(ov_count - ov0), 64'd1);
        chk_eq("t4_idle", 64'(busy), 64'd0);
        chk_eq("t4_present_held", 64'(allFMPSpresent), 64'd1);

        // 5: empty mask, zero timeout
        ready_mode = 1;
        enableMask = '0; fmpsBitmap = '0; timeoutCycles = '0;
        push_packet('0, '0, 1'b0);
        fa_pulse();
        wait_done("t5", 50);

        // 5b: reset in the middle of a stalled packet
        ready_mode = 0;
        enableMask = '1; fmpsBitmap = '1; timeoutCycles = 16'd5;
        push_packet('1, '1, 1'b0);
        fa_pulse();
        n = 0;
        while (!bus.M_TVALID && n < 100) begin
            @(negedge sysClk);
            n++;
        end
        chk_eq("t5b_stream_started", 64'(bus.M_TVALID), 64'd1);
        #2 sysReset_n = 1'b0;
        #1;
        chk_eq("t5b_tvalid_dropped", 64'(bus.M_TVALID), 64'd0);
        chk_eq("t5b_busy_dropped", 64'(busy), 64'd0);
        chk_eq("t5b_tlast_clear", 64'(bus.M_TLAST), 64'd0);
        exp_q.delete();
        @(posedge sysClk);
        #1 sysReset_n = 1'b1;
        ready_mode = 1;
        repeat (3) @(negedge sysClk);
        chk_eq("t5b_stays_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
